// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Writeback-side driver of the register file's single write port. ALU results
//   are accepted directly. Load results are buffered in a small FIFO. One winner
//   per cycle is registered onto the write port. The FIFO head wins when the ALU
//   is idle. The head also wins when it has lost STARVE_LIMIT times in a row,
//   which guarantees load progress.
//   Pending-write status is reported for two query addresses so that issue logic
//   can stall on RAW hazards.
//
// Ports
//   clock, reset_n            : clock, synchronous active-low reset
//   alu_valid/ready/addr/data : ALU result handshake (alu_ready is combinational)
//   mem_valid/ready/addr/data : load result handshake into the FIFO
//   wr_en/wr_addr/wr_data     : registered register-file write port
//   q_addr1/2, q_pend1/2      : hazard queries against pending writes
//   fifo_count                : current load FIFO occupancy
module wb_write_arbiter #(
  parameter  int WIDTH        = 32,
  parameter  int NREGS        = 32,
  parameter  int DEPTH        = 4,
  parameter  int STARVE_LIMIT = 3,
  parameter  int ZERO_REG     = 1,
  localparam int AW           = $clog2(NREGS),
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [AW-1:0]    alu_addr,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_data,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    q_addr1,
  input  logic [AW-1:0]    q_addr2,
  output logic             q_pend1,
  output logic             q_pend2,
  output logic [CW-1:0]    fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [AW-1:0]    fifo_addr_q [DEPTH];
  logic [WIDTH-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve;

  logic             fifo_empty;
  logic             forced;
  logic             alu_win;
  logic             pop;
  logic             push;
  logic             vld_p0;
  logic             drop_p0;
  logic [AW-1:0]    addr_p0;
  logic [WIDTH-1:0] data_p0;

  logic             fifo_hit1;
  logic             fifo_hit2;
  logic [PW-1:0]    off;

  // Stage p0: arbitration between the ALU input and the FIFO head.
  // Readiness depends only on registered state, so a load pushed into an empty
  // FIFO becomes poppable only on the following cycle. A full FIFO gets no
  // credit for a same-cycle pop.
  assign fifo_empty = (count == '0);
  assign forced     = !fifo_empty && (starve == SW'(STARVE_LIMIT));
  assign alu_ready  = !forced;
  assign mem_ready  = (count != CW'(DEPTH));
  assign alu_win    = alu_valid && alu_ready;
  assign pop        = !fifo_empty && !alu_win;
  assign push       = mem_valid && mem_ready;
  assign fifo_count = count;

  assign vld_p0  = alu_win || pop;
  assign addr_p0 = alu_win ? alu_addr : fifo_addr_q[rd_ptr];
  assign data_p0 = alu_win ? alu_data : fifo_data_q[rd_ptr];
  // A winner addressed to the hardwired zero register still consumes its slot.
  assign drop_p0 = (ZERO_REG != 0) && (addr_p0 == '0);

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr_q[wr_ptr] <= mem_addr;
      fifo_data_q[wr_ptr] <= mem_data;
    end
  end

  // Stage p1: registered write port and FIFO/starvation bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      starve  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (fifo_empty || pop) begin
        starve <= '0;
      end else if (alu_win) begin
        starve <= starve + 1'b1;
      end
      wr_en <= vld_p0 && !drop_p0;
      if (vld_p0) begin
        wr_addr <= addr_p0;
        wr_data <= data_p0;
      end
    end
  end

  // Hazard lookup: an entry is live when its distance from the read pointer is
  // below the occupancy. Pointer arithmetic wraps because DEPTH is a power of 2.
  always_comb begin
    fifo_hit1 = 1'b0;
    fifo_hit2 = 1'b0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (CW'(off) < count) begin
        if (fifo_addr_q[i] == q_addr1) fifo_hit1 = 1'b1;
        if (fifo_addr_q[i] == q_addr2) fifo_hit2 = 1'b1;
      end
    end
  end

  assign q_pend1 = !((ZERO_REG != 0) && (q_addr1 == '0)) &&
                   ((wr_en && (wr_addr == q_addr1)) || fifo_hit1);
  assign q_pend2 = !((ZERO_REG != 0) && (q_addr2 == '0)) &&
                   ((wr_en && (wr_addr == q_addr2)) || fifo_hit2);

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
  localparam int AW    = $clog2(NREGS);
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset_n;
  logic             alu_valid, alu_ready;
  logic [AW-1:0]    alu_addr;
  logic [WIDTH-1:0] alu_data;
  logic             mem_valid, mem_ready;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    q_addr1, q_addr2;
  logic             q_pend1, q_pend2;
  logic [CW-1:0]    fifo_count;

  wb_write_arbiter #(
    .WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .ZERO_REG(1)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_pend1(q_pend1), .q_pend2(q_pend2),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } ent_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference model: a queue of buffered loads, a count of consecutive
  // head losses, and a scoreboard of expected register-file writes.
  ent_t fifo_q[$];
  ent_t exp_q[$];
  int   starve   = 0;
  bit   m_wr_en  = 1'b0;
  logic [AW-1:0] m_wr_addr = '0;
  bit   alu_acc  = 1'b0;
  bit   mem_acc  = 1'b0;
  bit   started  = 1'b0;

  always @(posedge clock) begin
    bit   had_load, a_rdy, m_rdy, win;
    ent_t w;
    started = 1'b1;
    if (!reset_n) begin
      fifo_q.delete();
      exp_q.delete();
      starve    = 0;
      m_wr_en   = 1'b0;
      m_wr_addr = '0;
      alu_acc   = 1'b0;
      mem_acc   = 1'b0;
    end else begin
      had_load = (fifo_q.size() != 0);
      a_rdy    = !(had_load && starve == LIMIT);
      m_rdy    = (fifo_q.size() != DEPTH);
      alu_acc  = alu_valid && a_rdy;
      mem_acc  = mem_valid && m_rdy;
      win      = 1'b0;
      w        = '0;
      if (alu_acc) begin
        win = 1'b1;
        w   = '{addr: alu_addr, data: alu_data};
        if (had_load) starve++;
      end else if (had_load) begin
        win    = 1'b1;
        w      = fifo_q.pop_front();
        starve = 0;
      end
      if (!had_load) starve = 0;
      if (mem_acc) fifo_q.push_back('{addr: mem_addr, data: mem_data});
      m_wr_en = win && (w.addr != 0);
      if (win) m_wr_addr = w.addr;
      if (m_wr_en) exp_q.push_back(w);
    end
  end

  function automatic bit model_pend(input logic [AW-1:0] q);
    bit hit;
    hit = m_wr_en && (m_wr_addr == q);
    foreach (fifo_q[i]) if (fifo_q[i].addr == q) hit = 1'b1;
    return (q != 0) && hit;
  endfunction

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clock) begin
    ent_t e;
    if (started) begin
      check("wr_en", {63'd0, wr_en}, {63'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (wr_en) begin
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_data", 64'(wr_data), 64'(e.data));
        end
      end
      check("fifo_count", 64'(fifo_count), 64'(fifo_q.size()));
      check("alu_ready", {63'd0, alu_ready},
            {63'd0, !(fifo_q.size() != 0 && starve == LIMIT)});
      check("mem_ready", {63'd0, mem_ready}, {63'd0, fifo_q.size() != DEPTH});
      check("q_pend1", {63'd0, q_pend1}, {63'd0, model_pend(q_addr1)});
      check("q_pend2", {63'd0, q_pend2}, {63'd0, model_pend(q_addr2)});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset held with both producers asserting valid.
    reset_n   = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd9;  alu_data = 32'h1111_1111;
    mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'h2222_2222;
    q_addr1   = 5'd9; q_addr2 = 5'd10;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_wr_en", {63'd0, wr_en}, 64'd0);
      check("reset_count", 64'(fifo_count), 64'd0);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset_n   = 1'b1;
    #1 check("release_mem_ready", {63'd0, mem_ready}, 64'd1);
    idle(2);

    // ALU only.
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
    step();
    alu_valid = 1'b0;
    check("alu_only_en",   {63'd0, wr_en}, 64'd1);
    check("alu_only_addr", 64'(wr_addr), 64'd5);
    check("alu_only_data", 64'(wr_data), 64'hDEAD_BEEF);
    step();
    check("alu_only_off", {63'd0, wr_en}, 64'd0);

    // Fill the FIFO while the ALU keeps winning, until starvation forces pops.
    alu_valid = 1'b1; alu_addr = 5'd20; alu_data = $urandom;
    mem_valid = 1'b1; mem_addr = 5'd1;  mem_data = $urandom;
    for (int c = 0; c < 20; c++) begin
      step();
      if (mem_valid && mem_acc) begin
        if (mem_addr == 5'd4) mem_valid = 1'b0;
        else begin mem_addr = mem_addr + 1'b1; mem_data = $urandom; end
      end
      if (alu_acc) begin alu_addr = AW'(20 + c % 8); alu_data = $urandom; end
    end
    idle(8);

    // Zero register.
    q_addr1 = 5'd0;
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h0000_1234;
    #1 check("zero_alu_ready", {63'd0, alu_ready}, 64'd1);
    step();
    alu_valid = 1'b0;
    check("zero_wr_en", {63'd0, wr_en}, 64'd0);
    check("zero_pend", {63'd0, q_pend1}, 64'd0);
    idle(2);

    // Hazard on a buffered load.
    q_addr1 = 5'd7; q_addr2 = 5'd8;
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h0BAD_F00D;
    step();
    mem_valid = 1'b0;
    check("hazard_pend1", {63'd0, q_pend1}, 64'd1);
    check("hazard_pend2", {63'd0, q_pend2}, 64'd0);
    idle(5);

    // Full FIFO with both producers busy, then a mid-operation reset.
    alu_valid = 1'b1; mem_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (!alu_valid || alu_acc || c == 0) begin alu_addr = AW'($urandom_range(1, 15)); alu_data = $urandom; end
      if (!mem_valid || mem_acc || c == 0) begin mem_addr = AW'($urandom_range(1, 15)); mem_data = $urandom; end
      step();
    end
    reset_n = 1'b0;
    step();
    check("midreset_count", 64'(fifo_count), 64'd0);
    reset_n = 1'b1;
    idle(2);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (!(alu_valid && !alu_acc)) begin
        alu_valid = ($urandom_range(0, 99) < 55);
        alu_addr  = AW'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!(mem_valid && !mem_acc)) begin
        mem_valid = ($urandom_range(0, 99) < 45);
        mem_addr  = AW'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      q_addr1 = AW'($urandom_range(0, 8));
      q_addr2 = AW'($urandom_range(0, 8));
      reset_n = ($urandom_range(0, 299) != 0);
      step();
    end
    reset_n = 1'b1;
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
